// File: rtl/dma_addr_count_pkg.sv
// Shared types and register offsets for the DMA address/count datapath.
package dma_addr_count_pkg;

  localparam int unsigned AW    = 16;
  localparam int unsigned NSLOT = 4;

  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_MODE   = 4'hB;
  localparam logic [3:0] REG_CLRFF  = 4'hC;
  localparam logic [3:0] REG_MCLR   = 4'hD;

  typedef enum logic [1:0] {
    VERIFY = 2'b00,
    WRITE  = 2'b01,
    READ   = 2'b10
  } xfer_type_t;

  typedef struct packed {
    logic       autoinit;
    logic       decrement;
    xfer_type_t xfer_type;
  } mode_t;

  // Mode register byte layout: [1:0] channel, [3:2] type, [4] autoinit, [5] decrement.
  function automatic mode_t decode_mode(input logic [5:2] db);
    mode_t m;
    m.autoinit  = db[4];
    m.decrement = db[5];
    m.xfer_type = xfer_type_t'(db[3:2]);
    return m;
  endfunction

endpackage

// File: rtl/dma_addr_count_if.sv
// CPU register bus of the DMA controller.
interface dma_addr_count_if;
  logic       CS_N;
  logic       AEN;
  logic       IOW_N;
  logic       IOR_N;
  logic [3:0] A;
  logic [7:0] DB_in;
  logic [7:0] DB_out;

  modport master (output CS_N, AEN, IOW_N, IOR_N, A, DB_in, input DB_out);
  modport slave  (input CS_N, AEN, IOW_N, IOR_N, A, DB_in, output DB_out);
endinterface

// File: rtl/dma_addr_count_channel_regs.sv
// One channel's base/current address and count plus mode; byte writes, step, autoinit.
module dma_addr_count_channel_regs
  import dma_addr_count_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  logic          wr_count_i,
  input  logic          wr_hi_i,
  input  logic [7:0]    wr_data_i,
  input  logic          mode_we_i,
  input  mode_t         mode_i,
  input  logic          step_i,
  output logic [AW-1:0] cur_addr_o,
  output logic [AW-1:0] cur_count_o,
  output logic          decrement_o,
  output xfer_type_t    xfer_type_o
);

  logic [AW-1:0] base_addr_q, base_addr_d;
  logic [AW-1:0] base_count_q, base_count_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW-1:0] cur_count_q, cur_count_d;
  mode_t         mode_q, mode_d;

  // A CPU byte write to this channel takes priority over a concurrent step.
  always_comb begin
    base_addr_d  = base_addr_q;
    base_count_d = base_count_q;
    cur_addr_d   = cur_addr_q;
    cur_count_d  = cur_count_q;
    mode_d       = mode_q;
    if (wr_i) begin
      if (wr_count_i) begin
        if (wr_hi_i) begin
          base_count_d[15:8] = wr_data_i;
          cur_count_d[15:8]  = wr_data_i;
        end else begin
          base_count_d[7:0] = wr_data_i;
          cur_count_d[7:0]  = wr_data_i;
        end
      end else begin
        if (wr_hi_i) begin
          base_addr_d[15:8] = wr_data_i;
          cur_addr_d[15:8]  = wr_data_i;
        end else begin
          base_addr_d[7:0] = wr_data_i;
          cur_addr_d[7:0]  = wr_data_i;
        end
      end
    end else if (step_i) begin
      if (mode_q.autoinit && (cur_count_q == '0)) begin
        cur_addr_d  = base_addr_q;
        cur_count_d = base_count_q;
      end else begin
        cur_addr_d  = mode_q.decrement ? (cur_addr_q - AW'(1)) : (cur_addr_q + AW'(1));
        cur_count_d = cur_count_q - AW'(1);
      end
    end
    if (mode_we_i) mode_d = mode_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr_q  <= '0;
      base_count_q <= '0;
      cur_addr_q   <= '0;
      cur_count_q  <= '0;
      mode_q       <= '0;
    end else begin
      base_addr_q  <= base_addr_d;
      base_count_q <= base_count_d;
      cur_addr_q   <= cur_addr_d;
      cur_count_q  <= cur_count_d;
      mode_q       <= mode_d;
    end
  end

  assign cur_addr_o  = cur_addr_q;
  assign cur_count_o = cur_count_q;
  assign decrement_o = mode_q.decrement;
  assign xfer_type_o = mode_q.xfer_type;

endmodule

// File: rtl/dma_addr_count.sv
// DMA address/word-count datapath: CPU register decode, byte-pointer FF, TC status,
// per-channel registers and the active-channel output muxes.
module dma_addr_count
  import dma_addr_count_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic             clk,
  input  logic             rst,
  dma_addr_count_if.slave  bus,
  input  logic [1:0]       ch_sel,
  input  logic             step,
  input  logic             ldUpperAddr,
  output logic [7:0]       addr_lo,
  output logic [7:0]       addr_hi,
  output logic             carryPresent,
  output logic             TC,
  output logic             isRead
);

  logic       ff_q, ff_d;
  logic [3:0] status_q, status_d;
  logic       cpu_ok, wr, rd, ac_hit, mclr, rst_all, ch_valid;
  logic [3:0] tc_set;

  logic [AW-1:0] cur_addr  [NSLOT];
  logic [AW-1:0] cur_count [NSLOT];
  logic          dec_a     [NSLOT];
  xfer_type_t    type_a    [NSLOT];

  // Overlapping strobes or DMA bus ownership make the access invisible.
  assign cpu_ok   = !bus.CS_N && !bus.AEN && (bus.IOR_N || bus.IOW_N);
  assign wr       = cpu_ok && !bus.IOW_N;
  assign rd       = cpu_ok && !bus.IOR_N;
  assign ac_hit   = !bus.A[3];
  assign mclr     = wr && (bus.A == REG_MCLR);
  assign rst_all  = rst || mclr;
  assign ch_valid = 32'(ch_sel) < NCH;

  for (genvar c = 0; c < NSLOT; c++) begin : g_ch
    if (c < NCH) begin : g_on
      dma_addr_count_channel_regs u_regs (
        .clk        (clk),
        .rst        (rst_all),
        .wr_i       (wr && ac_hit && (bus.A[2:1] == 2'(c))),
        .wr_count_i (bus.A[0]),
        .wr_hi_i    (ff_q),
        .wr_data_i  (bus.DB_in),
        .mode_we_i  (wr && (bus.A == REG_MODE) && (bus.DB_in[1:0] == 2'(c))),
        .mode_i     (decode_mode(bus.DB_in[5:2])),
        .step_i     (step && (ch_sel == 2'(c))),
        .cur_addr_o (cur_addr[c]),
        .cur_count_o(cur_count[c]),
        .decrement_o(dec_a[c]),
        .xfer_type_o(type_a[c])
      );
    end else begin : g_off
      assign cur_addr[c]  = '0;
      assign cur_count[c] = '0;
      assign dec_a[c]     = 1'b0;
      assign type_a[c]    = VERIFY;
    end
  end

  always_comb begin
    tc_set = '0;
    if (step && ch_valid && (cur_count[ch_sel] == '0)) tc_set[ch_sel] = 1'b1;

    status_d = (rd && (bus.A == REG_STATUS)) ? 4'b0 : status_q;
    status_d = status_d | tc_set;

    ff_d = ff_q;
    if ((wr || rd) && ac_hit) ff_d = ~ff_q;
    if (wr && (bus.A == REG_CLRFF)) ff_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_all) begin
      ff_q     <= 1'b0;
      status_q <= '0;
    end else begin
      ff_q     <= ff_d;
      status_q <= status_d;
    end
  end

  // Read data is combinational so it is valid within the single-cycle IOR_N pulse.
  always_comb begin
    bus.DB_out = 8'h00;
    if (rd) begin
      if (ac_hit) begin
        if (bus.A[0]) bus.DB_out = ff_q ? cur_count[bus.A[2:1]][15:8] : cur_count[bus.A[2:1]][7:0];
        else          bus.DB_out = ff_q ? cur_addr[bus.A[2:1]][15:8]  : cur_addr[bus.A[2:1]][7:0];
      end else if (bus.A == REG_STATUS) begin
        bus.DB_out = {4'b0, status_q};
      end
    end
  end

  assign addr_lo      = cur_addr[ch_sel][7:0];
  assign addr_hi      = ldUpperAddr ? cur_addr[ch_sel][15:8] : 8'h00;
  assign carryPresent = ch_valid && (dec_a[ch_sel] ? (cur_addr[ch_sel][7:0] == 8'h00)
                                                   : (cur_addr[ch_sel][7:0] == 8'hFF));
  assign TC           = ch_valid && (cur_count[ch_sel] == '0);
  assign isRead       = ch_valid && (type_a[ch_sel] == READ);

endmodule
